ff_ram_mp: RTL and testbench



---
 rtl/ff_ram_pkg.sv | 25 ++
 rtl/ff_ram_mp_rr_arbiter.sv | 51 +++++
 rtl/ff_ram_mp.sv | 201 ++++++++++++++++++++
 tb/tb_ff_ram_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_ram_pkg.sv
// Shared types, constants and helpers for the multi-port flop RAM.
package ff_ram_pkg;

  // Data returned on every errored read, replicated or truncated to the word width.
  localparam logic [31:0] FF_RAM_ERR_PATTERN = 32'hDEAD_BEEF;

  // Widest word the response struct can carry; narrower words use the low bits.
  localparam int FF_RAM_MAX_WORD = 128;

  // One response beat for one port.
  typedef struct packed {
    logic                       rvalid;
    logic                       err;
    logic [FF_RAM_MAX_WORD-1:0] rdata;
  } ff_ram_rsp_t;

  // True when addr falls inside [base, base+size); the subtraction form
  // stays correct even when base+size would wrap past 32 bits.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/ff_ram_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to winner+1 whenever advance_i is set.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_winner;
  logic          w_found;

  // Modulo-N increment that also works for non power-of-two N.
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] base,
                                           input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N) sum = sum - N;
    return PW'(sum);
  endfunction

  // Search requesters starting at the pointer and pick the first one.
  always_comb begin
    gnt_o    = '0;
    w_winner = r_ptr;
    w_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req_i[ptrAdd(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = ptrAdd(r_ptr, k);
      end
    end
    if (w_found) gnt_o[w_winner] = 1'b1;
  end

  // Pointer register: rotate past the winner so it gets lowest priority next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance_i && w_found) begin
      r_ptr <= ptrAdd(w_winner, 1);
    end
  end

endmodule

// File: rtl/ff_ram_mp.sv
// Multi-port flop-based scratchpad RAM with OBI slave ports. Every port can
// read every cycle; write-capable ports share one write slot per cycle via a
// round-robin arbiter. Bad accesses get an error response and are counted.
module ff_ram_mp
  import ff_ram_pkg::*;
#(
  parameter int                   NUM_PORTS      = 2,
  parameter logic [31:0]          SRAM_BASE_ADDR = 32'h8000_0000,
  parameter int                   SRAM_SIZE      = 1024,
  parameter int                   WORD_SIZE      = 32,
  parameter int                   READ_LATENCY   = 1,
  // Default lets only port 0 (the data bus) write.
  parameter logic [NUM_PORTS-1:0] WRITE_MASK     = NUM_PORTS'(1),
  parameter int                   ADDR_WIDTH     = $clog2(SRAM_SIZE / (WORD_SIZE / 8))
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]            addr_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][WORD_SIZE/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][WORD_SIZE-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]                  err_o,
  output logic                                  illegal_memory_o,
  output logic [15:0]                           err_count_o
);

  localparam int BYTES      = WORD_SIZE / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int DEPTH      = SRAM_SIZE / BYTES;
  localparam logic [WORD_SIZE-1:0] ERR_WORD =
    WORD_SIZE'({((WORD_SIZE + 31) / 32){FF_RAM_ERR_PATTERN}});

  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic [NUM_PORTS-1:0]                 w_legal;
  logic [NUM_PORTS-1:0]                 w_wrErr;
  logic [NUM_PORTS-1:0]                 w_rdErr;
  logic [NUM_PORTS-1:0]                 w_wrReq;
  logic [NUM_PORTS-1:0]                 w_arbGnt;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_idx;
  logic                                 w_advance;

  logic                  w_wrEn;
  logic [ADDR_WIDTH-1:0] w_wrIdx;
  logic [BYTES-1:0]      w_wrBe;
  logic [WORD_SIZE-1:0]  w_wrData;

  ff_ram_rsp_t [NUM_PORTS-1:0] w_rsp;
  ff_ram_rsp_t [NUM_PORTS-1:0] r_rsp1;
  ff_ram_rsp_t [NUM_PORTS-1:0] w_rspOut;

  logic [NUM_PORTS-1:0] w_errBits;
  logic [2:0]           w_errPop;
  logic [16:0]          w_cntSum;
  logic [15:0]          r_errCount;

  // Address decode: window check, word index and per-port error classification.
  always_comb begin
    w_legal = '0;
    w_idx   = '0;
    w_wrErr = '0;
    w_rdErr = '0;
    w_wrReq = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_legal[p] = in_window(addr_i[p], SRAM_BASE_ADDR, 32'(SRAM_SIZE));
      w_idx[p]   = ADDR_WIDTH'((addr_i[p] - SRAM_BASE_ADDR) >> BYTE_SHIFT);
      w_wrErr[p] = req_i[p] && we_i[p] && (!WRITE_MASK[p] || !w_legal[p]);
      w_rdErr[p] = req_i[p] && !we_i[p] && !w_legal[p];
      w_wrReq[p] = req_i[p] && we_i[p] && WRITE_MASK[p] && w_legal[p];
    end
  end

  // Errored writes never reach the arbiter, so they cannot move its pointer.
  assign w_advance = |w_wrReq;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (w_wrReq),
    .advance_i (w_advance),
    .gnt_o     (w_arbGnt)
  );

  // Grant: reads and errored writes always, legal writes only when they win.
  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_o[p] = req_i[p] && (!we_i[p] || w_wrErr[p] || w_arbGnt[p]);
    end
  end

  // Mux the single winning write onto the memory write port.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrIdx  = '0;
    w_wrBe   = '0;
    w_wrData = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_arbGnt[p]) begin
        w_wrEn   = 1'b1;
        w_wrIdx  = w_idx[p];
        w_wrBe   = be_i[p];
        w_wrData = wdata_i[p];
      end
    end
  end

  // Byte-wise commit at the clock edge; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (w_wrEn) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wrBe[b]) r_mem[w_wrIdx][b*8 +: 8] <= w_wrData[b*8 +: 8];
      end
    end
  end

  // Build this cycle's responses; reads see pre-write data because the array
  // only changes at the edge that also captures these responses.
  always_comb begin
    w_rsp = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rsp[p].rvalid = gnt_o[p];
      w_rsp[p].err    = w_wrErr[p] || w_rdErr[p];
      if (gnt_o[p] && !we_i[p]) begin
        w_rsp[p].rdata = w_rdErr[p] ? FF_RAM_MAX_WORD'(ERR_WORD)
                                    : FF_RAM_MAX_WORD'(r_mem[w_idx[p]]);
      end
    end
  end

  // First response stage; reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rsp1 <= '0;
    else       r_rsp1 <= w_rsp;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      ff_ram_rsp_t [NUM_PORTS-1:0] r_rsp2;

      // Optional second stage for timing; still one beat per port per cycle.
      always_ff @(posedge clk_i) begin
        if (rst_i) r_rsp2 <= '0;
        else       r_rsp2 <= r_rsp1;
      end

      assign w_rspOut = r_rsp2;
    end else begin : g_lat1
      assign w_rspOut = r_rsp1;
    end
  endgenerate

  // Unpack the final stage onto the OBI response ports and count errors.
  always_comb begin
    rvalid_o  = '0;
    err_o     = '0;
    rdata_o   = '0;
    w_errBits = '0;
    w_errPop  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p]  = w_rspOut[p].rvalid;
      err_o[p]     = w_rspOut[p].err;
      rdata_o[p]   = w_rspOut[p].rdata[WORD_SIZE-1:0];
      w_errBits[p] = w_rspOut[p].rvalid && w_rspOut[p].err;
      w_errPop     = w_errPop + {2'b00, w_errBits[p]};
    end
  end

  generate
    if (WORD_SIZE < FF_RAM_MAX_WORD) begin : g_unusedHi
      logic [NUM_PORTS-1:0] w_unusedHi;

      // Upper struct bits are always zero for narrow words.
      always_comb begin
        w_unusedHi = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          w_unusedHi[p] = |w_rspOut[p].rdata[FF_RAM_MAX_WORD-1:WORD_SIZE];
        end
      end
    end
  endgenerate

  assign illegal_memory_o = |w_errBits;
  assign w_cntSum         = {1'b0, r_errCount} + 17'(w_errPop);

  // Saturating error counter, updated from the responses just presented.
  always_ff @(posedge clk_i) begin
    if (rst_i)            r_errCount <= '0;
    else if (w_cntSum[16]) r_errCount <= 16'hFFFF;
    else                  r_errCount <= w_cntSum[15:0];
  end

  assign err_count_o = r_errCount;

endmodule

// File: tb/tb_ff_ram_mp.sv
// Directed bench for ff_ram_mp: a 3-port instance (ports 0/1 write-capable,
// port 2 read-only) at latency 1, plus a 1-port instance at latency 2.
module tb_ff_ram_mp;

  logic clk;
  logic rst;

  logic [2:0]       req, we, gnt, rvalid, err;
  logic [2:0][31:0] addr, wdata, rdata;
  logic [2:0][3:0]  be;
  logic             illegal;
  logic [15:0]      errCount;

  logic [0:0]       l2Req, l2We, l2Gnt, l2Rvalid, l2Err;
  logic [0:0][31:0] l2Addr, l2Wdata, l2Rdata;
  logic [0:0][3:0]  l2Be;
  logic             l2Illegal;
  logic [15:0]      l2ErrCount;

  int checks   = 0;
  int failures = 0;

  ff_ram_mp #(
    .NUM_PORTS    (3),
    .READ_LATENCY (1),
    .WRITE_MASK   (3'b011)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .gnt_o            (gnt),
    .addr_i           (addr),
    .we_i             (we),
    .be_i             (be),
    .wdata_i          (wdata),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_o            (err),
    .illegal_memory_o (illegal),
    .err_count_o      (errCount)
  );

  ff_ram_mp #(
    .NUM_PORTS    (1),
    .READ_LATENCY (2),
    .WRITE_MASK   (1'b1)
  ) dutL2 (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (l2Req),
    .gnt_o            (l2Gnt),
    .addr_i           (l2Addr),
    .we_i             (l2We),
    .be_i             (l2Be),
    .wdata_i          (l2Wdata),
    .rvalid_o         (l2Rvalid),
    .rdata_o          (l2Rdata),
    .err_o            (l2Err),
    .illegal_memory_o (l2Illegal),
    .err_count_o      (l2ErrCount)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int p, input logic rq, input logic w,
                               input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
    req[p]   = rq;
    we[p]    = w;
    addr[p]  = a;
    be[p]    = b;
    wdata[p] = d;
  endtask

  task automatic applyL2(input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    l2Req[0]   = rq;
    l2We[0]    = w;
    l2Addr[0]  = a;
    l2Be[0]    = 4'hF;
    l2Wdata[0] = d;
  endtask

  task automatic idleAll();
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idleAll();
    applyL2(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rvalid", 32'(rvalid), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset rdata1", rdata[1], 32'h0);
    checkOutput("reset illegal", 32'(illegal), 32'h0);
    checkOutput("reset errCount", 32'(errCount), 32'h0);
    checkOutput("reset l2 rvalid", 32'(l2Rvalid), 32'h0);
    rst = 1'b0;

    // Full write on port 0 in the first cycle out of reset, then read on port 1.
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D);
    #1 checkOutput("wr gnt", 32'(gnt), 32'h1);
    tick();
    checkOutput("wr rvalid", 32'(rvalid), 32'h1);
    checkOutput("wr err", 32'(err), 32'h0);
    checkOutput("wr rdata0", rdata[0], 32'h0);
    idleAll();
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    #1 checkOutput("rd gnt", 32'(gnt), 32'h2);
    tick();
    checkOutput("rd rvalid", 32'(rvalid), 32'h2);
    checkOutput("rd rdata1", rdata[1], 32'hCAFE_F00D);
    checkOutput("rd err", 32'(err), 32'h0);
    idleAll();
    tick();
    checkOutput("idle rvalid", 32'(rvalid), 32'h0);

    // Partial byte write over a full word.
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'h1122_3344);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0020, 4'b0010, 32'h0000_AB00);
    tick();
    idleAll();
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    tick();
    checkOutput("partial rdata1", rdata[1], 32'h1122_AB44);

    // Single port 1 write leaves the round-robin pointer at port 2.
    idleAll();
    applyStimulus(1, 1'b1, 1'b1, 32'h8000_0030, 4'hF, 32'h55AA_55AA);
    #1 checkOutput("p1 wr gnt", 32'(gnt), 32'h2);
    tick();

    // Contending writers: losers hold, grants alternate p0, p1, p0, p1.
    idleAll();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0100, 4'hF, 32'h1111_0000);
    applyStimulus(1, 1'b1, 1'b1, 32'h8000_0200, 4'hF, 32'h2222_0000);
    #1 checkOutput("arb c1 gnt", 32'(gnt), 32'h1);
    tick();
    checkOutput("arb c1 rvalid", 32'(rvalid), 32'h1);
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0104, 4'hF, 32'h1111_0001);
    #1 checkOutput("arb c2 gnt", 32'(gnt), 32'h2);
    tick();
    checkOutput("arb c2 rvalid", 32'(rvalid), 32'h2);
    applyStimulus(1, 1'b1, 1'b1, 32'h8000_0204, 4'hF, 32'h2222_0001);
    #1 checkOutput("arb c3 gnt", 32'(gnt), 32'h1);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0108, 4'hF, 32'h1111_0002);
    #1 checkOutput("arb c4 gnt", 32'(gnt), 32'h2);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 checkOutput("arb c5 gnt", 32'(gnt), 32'h1);
    tick();
    idleAll();
    applyStimulus(0, 1'b1, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0200, 4'h0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h8000_0104, 4'h0, 32'h0);
    #1 checkOutput("triple rd gnt", 32'(gnt), 32'h7);
    tick();
    checkOutput("arb A0", rdata[0], 32'h1111_0000);
    checkOutput("arb B0", rdata[1], 32'h2222_0000);
    checkOutput("arb A1", rdata[2], 32'h1111_0001);
    applyStimulus(0, 1'b1, 1'b0, 32'h8000_0204, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0108, 4'h0, 32'h0);
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    checkOutput("arb B1", rdata[0], 32'h2222_0001);
    checkOutput("arb A2", rdata[1], 32'h1111_0002);

    // Word 0 gets a known value so an aliased out-of-range write would show.
    idleAll();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0000, 4'hF, 32'h1357_9BDF);
    tick();

    // Out-of-range read on port 0 and out-of-range write on port 1 together.
    idleAll();
    applyStimulus(0, 1'b1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h8000_0400, 4'hF, 32'hFFFF_FFFF);
    #1 checkOutput("oor gnt", 32'(gnt), 32'h3);
    tick();
    checkOutput("oor rvalid", 32'(rvalid), 32'h3);
    checkOutput("oor err", 32'(err), 32'h3);
    checkOutput("oor rdata0", rdata[0], 32'hDEAD_BEEF);
    checkOutput("oor rdata1", rdata[1], 32'h0);
    checkOutput("oor illegal", 32'(illegal), 32'h1);
    checkOutput("oor count before", 32'(errCount), 32'h0);
    idleAll();
    applyStimulus(0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
    tick();
    checkOutput("oor illegal drop", 32'(illegal), 32'h0);
    checkOutput("oor count after", 32'(errCount), 32'h2);
    checkOutput("oor no alias", rdata[0], 32'h1357_9BDF);

    // Pointer is still at port 1 because the errored write did not move it.
    idleAll();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0040, 4'hF, 32'h4040_4040);
    applyStimulus(1, 1'b1, 1'b1, 32'h8000_0044, 4'hF, 32'h4444_4444);
    #1 checkOutput("ptr hold gnt", 32'(gnt), 32'h2);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 checkOutput("ptr hold gnt2", 32'(gnt), 32'h1);
    tick();

    // Write from read-only port 2 errors and leaves memory untouched.
    idleAll();
    applyStimulus(2, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'h1234_5678);
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    #1 checkOutput("ro gnt", 32'(gnt), 32'h6);
    tick();
    checkOutput("ro rvalid", 32'(rvalid), 32'h6);
    checkOutput("ro err", 32'(err), 32'h4);
    checkOutput("ro same-cycle rd", rdata[1], 32'hCAFE_F00D);
    idleAll();
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    tick();
    checkOutput("ro readback", rdata[1], 32'hCAFE_F00D);
    checkOutput("ro count", 32'(errCount), 32'h3);

    // Same-cycle read and write of one word returns the old contents.
    idleAll();
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'h9999_9999);
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    #1 checkOutput("rbw gnt", 32'(gnt), 32'h3);
    tick();
    checkOutput("rbw old", rdata[1], 32'h1122_AB44);
    idleAll();
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    tick();
    checkOutput("rbw new", rdata[1], 32'h9999_9999);

    // Reset with a read in flight drops the response and clears the counter.
    idleAll();
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    rst = 1'b1;
    tick();
    checkOutput("rst rvalid", 32'(rvalid), 32'h0);
    checkOutput("rst rdata1", rdata[1], 32'h0);
    checkOutput("rst count", 32'(errCount), 32'h0);
    checkOutput("rst illegal", 32'(illegal), 32'h0);
    rst = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    tick();
    checkOutput("post rst rvalid", 32'(rvalid), 32'h2);
    checkOutput("post rst rdata1", rdata[1], 32'h9999_9999);
    idleAll();

    // Two-cycle latency instance.
    applyL2(1'b1, 1'b1, 32'h8000_0008, 32'hA5A5_A5A5);
    #1 checkOutput("l2 wr gnt", 32'(l2Gnt), 32'h1);
    tick();
    checkOutput("l2 wr early", 32'(l2Rvalid), 32'h0);
    applyL2(1'b1, 1'b0, 32'h8000_0008, 32'h0);
    tick();
    checkOutput("l2 wr rvalid", 32'(l2Rvalid), 32'h1);
    checkOutput("l2 wr rdata", l2Rdata[0], 32'h0);
    applyL2(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("l2 rd rvalid", 32'(l2Rvalid), 32'h1);
    checkOutput("l2 rd rdata", l2Rdata[0], 32'hA5A5_A5A5);
    tick();
    checkOutput("l2 idle rvalid", 32'(l2Rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
